// File: rtl/ser_frame_pkg.sv
// Shared parameters, state type and frame-length helper for the serial frame
// transmitter and the receiver-side controller.
package ser_frame_pkg;

  localparam int unsigned DEF_PORT_W = 2;
  localparam int unsigned DEF_LEN_W  = 4;
  localparam int unsigned DEF_DATA_W = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_START,
    ST_PORT,
    ST_LEN,
    ST_DATA,
    ST_STOP
  } tx_state_t;

  // Bit periods on the line: start + port + length + payload + stop.
  function automatic int unsigned frame_len(input int unsigned len);
    return 2 + DEF_PORT_W + DEF_LEN_W + len;
  endfunction

endpackage

// File: rtl/frame_shifter.sv
// Loadable LSB-out field shift register with a remaining-bit down-counter.
// Load/shift only take effect on clk_en cycles.
module frame_shifter
  import ser_frame_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] load_val,
  input  logic [CNT_W-1:0]  load_cnt,
  output logic              head,
  output logic              last
);

  logic [DATA_W-1:0] sr;
  logic [CNT_W-1:0]  cnt;

  // The caller emits load_val[0] itself on the load cycle, so only the
  // remaining bits are kept here.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clk_en) begin
      if (load) begin
        sr  <= load_val >> 1;
        cnt <= load_cnt;
      end else if (shift) begin
        sr  <= sr >> 1;
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign head = sr[0];
  assign last = (cnt == '0);

endmodule

// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: captures one request and sends start, port (MSB
// first), length (MSB first), payload (LSB first) and stop, one bit per clk_en.
module ser_frame_tx
  import ser_frame_pkg::*;
#(
  parameter int unsigned PORT_W = DEF_PORT_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              start,
  input  logic [PORT_W-1:0] port_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ser_out,
  output logic              busy,
  output logic              done,
  output logic              reject
);

  tx_state_t         state;
  logic [PORT_W-1:0] port_q;
  logic [LEN_W-1:0]  len_q;
  logic [DATA_W-1:0] data_q;

  logic [PORT_W-1:0] port_rev;
  logic [LEN_W-1:0]  len_rev;
  logic              sh_load, sh_shift, sh_head, sh_last;
  logic [DATA_W-1:0] sh_val;
  logic [LEN_W-1:0]  sh_cnt;

  // MSB-first fields are bit-reversed so the shifter can always send LSB out.
  always_comb begin
    port_rev = '0;
    len_rev  = '0;
    for (int unsigned i = 0; i < PORT_W; i++) port_rev[i] = port_q[PORT_W-1-i];
    for (int unsigned i = 0; i < LEN_W; i++)  len_rev[i]  = len_q[LEN_W-1-i];
  end

  always_comb begin
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_val   = '0;
    sh_cnt   = '0;
    case (state)
      ST_START: begin
        sh_load = 1'b1;
        sh_val  = DATA_W'(port_rev);
        sh_cnt  = LEN_W'(PORT_W - 1);
      end
      ST_PORT: begin
        if (sh_last) begin
          sh_load = 1'b1;
          sh_val  = DATA_W'(len_rev);
          sh_cnt  = LEN_W'(LEN_W - 1);
        end else begin
          sh_shift = 1'b1;
        end
      end
      ST_LEN: begin
        if (sh_last) begin
          sh_load = 1'b1;
          sh_val  = data_q;
          sh_cnt  = len_q - LEN_W'(1);
        end else begin
          sh_shift = 1'b1;
        end
      end
      ST_DATA:  sh_shift = !sh_last;
      default: ;
    endcase
  end

  frame_shifter #(
    .DATA_W (DATA_W),
    .CNT_W  (LEN_W)
  ) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .clk_en   (clk_en),
    .load     (sh_load),
    .shift    (sh_shift),
    .load_val (sh_val),
    .load_cnt (sh_cnt),
    .head     (sh_head),
    .last     (sh_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      ser_out <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      reject  <= 1'b0;
      port_q  <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          ser_out <= 1'b1;
          if (start) begin
            if (len_in != '0) begin
              port_q <= port_in;
              len_q  <= len_in;
              data_q <= data_in;
              busy   <= 1'b1;
              state  <= ST_ARMED;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        ST_ARMED: if (clk_en) begin
          ser_out <= 1'b0;
          state   <= ST_START;
        end
        ST_START: if (clk_en) begin
          ser_out <= sh_val[0];
          state   <= ST_PORT;
        end
        ST_PORT: if (clk_en) begin
          ser_out <= sh_last ? sh_val[0] : sh_head;
          if (sh_last) state <= ST_LEN;
        end
        ST_LEN: if (clk_en) begin
          ser_out <= sh_last ? sh_val[0] : sh_head;
          if (sh_last) state <= ST_DATA;
        end
        ST_DATA: if (clk_en) begin
          if (sh_last) begin
            ser_out <= 1'b1;
            state   <= ST_STOP;
          end else begin
            ser_out <= sh_head;
          end
        end
        ST_STOP: if (clk_en) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ser_frame_tx.sv
// Directed bench for ser_frame_tx: each task drives one scenario and checks
// {ser_out, busy, done, reject} against hand-computed values.
module tb_ser_frame_tx;

  logic        clk = 1'b0;
  logic        rst, clk_en, start;
  logic [1:0]  port_in;
  logic [3:0]  len_in;
  logic [14:0] data_in;
  logic        ser_out, busy, done, reject;

  int checks = 0;
  int errors = 0;

  ser_frame_tx #(
    .PORT_W (2),
    .LEN_W  (4),
    .DATA_W (15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clk_en  (clk_en),
    .start   (start),
    .port_in (port_in),
    .len_in  (len_in),
    .data_in (data_in),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done),
    .reject  (reject)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; clk_en = 1'b0; start = 1'b0;
    port_in = '0; len_in = '0; data_in = '0;
    tick; tick;
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state got %b exp 1000", {ser_out, busy, done, reject});
    end
    rst = 1'b0;
    tick;
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset got %b exp 1000", {ser_out, busy, done, reject});
    end
  endtask

  // port=10 len=3 data=101, clk_en held high
  task automatic test_basic_frame;
    logic [11:0] exp_bits;
    exp_bits = 12'b1010_0011_1011;
    clk_en = 1'b1; start = 1'b1; port_in = 2'b10; len_in = 4'd3; data_in = 15'b101;
    tick;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({ser_out, busy, done, reject} !== {exp_bits[11-i], 3'b100}) begin
        errors++;
        $display("FAIL basic_bit%0d got %b exp %b", i, {ser_out, busy, done, reject},
                 {exp_bits[11-i], 3'b100});
      end
      tick;
    end
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1010) begin
      errors++;
      $display("FAIL basic_done got %b exp 1010", {ser_out, busy, done, reject});
    end
    tick;
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1000) begin
      errors++;
      $display("FAIL basic_idle got %b exp 1000", {ser_out, busy, done, reject});
    end
  endtask

  // clk_en every 4th clk, port=01 len=1 data=1: 9 bit periods
  task automatic test_clk_en;
    logic [8:0] f;
    int k, done_cnt;
    logic exp_ser, exp_busy, exp_done;
    f = 9'b0_01_0001_1_1;
    k = 0; done_cnt = 0;
    clk_en = 1'b0; start = 1'b1; port_in = 2'b01; len_in = 4'd1; data_in = 15'h7FFF;
    tick;
    start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      clk_en = (cyc % 4 == 0);
      tick;
      if (clk_en) k++;
      exp_ser  = (k == 0) ? 1'b1 : (k <= 9) ? f[9-k] : 1'b1;
      exp_busy = (k <= 9);
      exp_done = clk_en && (k == 10);
      if (done) done_cnt++;
      checks++;
      if ({ser_out, busy, done} !== {exp_ser, exp_busy, exp_done}) begin
        errors++;
        $display("FAIL clken_cyc%0d got %b exp %b", cyc, {ser_out, busy, done},
                 {exp_ser, exp_busy, exp_done});
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL clken_done_count got %0d exp 1", done_cnt);
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reject;
    clk_en = 1'b1; start = 1'b1; port_in = 2'b01; len_in = 4'd0; data_in = 15'd7;
    tick;
    start = 1'b0;
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1001) begin
      errors++;
      $display("FAIL reject_pulse got %b exp 1001", {ser_out, busy, done, reject});
    end
    tick;
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1000) begin
      errors++;
      $display("FAIL reject_clear got %b exp 1000", {ser_out, busy, done, reject});
    end
  endtask

  // Second start while busy is ignored; a start in the done cycle is accepted.
  task automatic test_back_to_back;
    logic [11:0] exp_bits;
    logic seen;
    exp_bits = 12'b1010_0011_1011;
    clk_en = 1'b1; start = 1'b1; port_in = 2'b10; len_in = 4'd3; data_in = 15'b101;
    tick;
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if ({ser_out, busy, done, reject} !== {exp_bits[11-i], 3'b100}) begin
        errors++;
        $display("FAIL b2b_bit%0d got %b exp %b", i, {ser_out, busy, done, reject},
                 {exp_bits[11-i], 3'b100});
      end
      if (i == 3) begin
        start = 1'b1; port_in = 2'b11; len_in = 4'd5; data_in = 15'h1F;
      end else begin
        start = 1'b0;
      end
      tick;
    end
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1010) begin
      errors++;
      $display("FAIL b2b_done got %b exp 1010", {ser_out, busy, done, reject});
    end
    start = 1'b1; port_in = 2'b01; len_in = 4'd1; data_in = 15'd1;
    tick;
    start = 1'b0;
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1100) begin
      errors++;
      $display("FAIL b2b_recapture got %b exp 1100", {ser_out, busy, done, reject});
    end
    tick;
    checks++;
    if ({ser_out, busy} !== 2'b01) begin
      errors++;
      $display("FAIL b2b_startbit got %b exp 01", {ser_out, busy});
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick;
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL b2b_second_done got 0 exp 1 (timeout)");
    end
  endtask

  // Reset during payload bit 2 of a len=15 frame
  task automatic test_reset_mid;
    clk_en = 1'b1; start = 1'b1; port_in = 2'b10; len_in = 4'd15; data_in = 15'h7FFB;
    tick;
    start = 1'b0;
    for (int i = 0; i < 10; i++) tick;
    checks++;
    if ({ser_out, busy} !== 2'b01) begin
      errors++;
      $display("FAIL mid_data_bit2 got %b exp 01", {ser_out, busy});
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if ({ser_out, busy, done, reject} !== 4'b1000) begin
      errors++;
      $display("FAIL mid_reset got %b exp 1000", {ser_out, busy, done, reject});
    end
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++;
      if ({ser_out, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL mid_after%0d got %b exp 100", i, {ser_out, busy, done});
      end
    end
  endtask

  // Bench-side receiver decodes a len=15 all-ones frame
  task automatic test_loopback;
    logic [22:0] rx;
    logic [14:0] payload;
    clk_en = 1'b1; start = 1'b1; port_in = 2'b01; len_in = 4'd15; data_in = 15'h7FFF;
    tick;
    start = 1'b0;
    rx = '0;
    for (int i = 0; i < 23; i++) begin
      tick;
      rx[22-i] = ser_out;
    end
    for (int j = 0; j < 15; j++) payload[j] = rx[15-j];
    checks++;
    if (rx[22] !== 1'b0) begin
      errors++;
      $display("FAIL loop_start got %b exp 0", rx[22]);
    end
    checks++;
    if (rx[21:20] !== 2'b01) begin
      errors++;
      $display("FAIL loop_port got %b exp 01", rx[21:20]);
    end
    checks++;
    if (rx[19:16] !== 4'b1111) begin
      errors++;
      $display("FAIL loop_len got %b exp 1111", rx[19:16]);
    end
    checks++;
    if (payload !== 15'h7FFF) begin
      errors++;
      $display("FAIL loop_payload got %h exp 7fff", payload);
    end
    checks++;
    if (rx[0] !== 1'b1) begin
      errors++;
      $display("FAIL loop_stop got %b exp 1", rx[0]);
    end
    tick;
    checks++;
    if ({ser_out, busy, done} !== 3'b101) begin
      errors++;
      $display("FAIL loop_done got %b exp 101", {ser_out, busy, done});
    end
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_clk_en;
    test_reject;
    test_back_to_back;
    test_reset_mid;
    test_loopback;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
